// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared Y86 execute-stage encodings for the condition-code unit
package y86_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_XOR = 4'd3
    } alu_fun_e;

    typedef enum logic [3:0] {
        C_ALWAYS = 4'd0,
        C_LE     = 4'd1,
        C_L      = 4'd2,
        C_E      = 4'd3,
        C_NE     = 4'd4,
        C_GE     = 4'd5,
        C_G      = 4'd6
    } cond_e;

    typedef enum logic [1:0] {
        STAT_AOK = 2'd0,
        STAT_HLT = 2'd1,
        STAT_ADR = 2'd2,
        STAT_INS = 2'd3
    } stat_e;

    localparam logic RST_ZF = 1'b1;
    localparam logic RST_SF = 1'b0;
    localparam logic RST_OF = 1'b0;

endpackage

// File: rtl/cc_cond_eval.sv
// rtl/cc_cond_eval.sv - combinational jXX/cmovXX condition decoder from ZF/SF/OF
module cc_cond_eval
    import y86_pkg::*;
(
    input  logic [3:0] cond_fun,
    input  logic       zf,
    input  logic       sf,
    input  logic       of,
    output logic       cnd
);

    logic lt;

    // Signed less-than after a compare is SF differing from OF.
    assign lt = sf ^ of;

    always_comb begin
        cnd = 1'b0;
        case (cond_fun)
            C_ALWAYS: cnd = 1'b1;
            C_LE:     cnd = lt | zf;
            C_L:      cnd = lt;
            C_E:      cnd = zf;
            C_NE:     cnd = ~zf;
            C_GE:     cnd = ~lt;
            C_G:      cnd = ~lt & ~zf;
            default:  cnd = 1'b0;
        endcase
    end

endmodule

// File: rtl/cc_unit.sv
// rtl/cc_unit.sv - Y86 condition-code register and cnd generation; CC_STATS_EN adds eval/taken counters
module cc_unit
    import y86_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_cc,
    input  logic [3:0]       alu_fun,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_ovf,
    input  logic [1:0]       m_stat,
    input  logic [1:0]       w_stat,
    input  logic [3:0]       cond_fun,
    input  logic             eval_valid,
    output logic             zf,
    output logic             sf,
    output logic             of,
    output logic             cnd
`ifdef CC_STATS_EN
    ,
    output logic [CNT_W-1:0] eval_cnt,
    output logic [CNT_W-1:0] taken_cnt
`endif
);

    logic upd;
    logic arith;

    // An exception already in M or W must not see its successors change the flags.
    assign upd   = set_cc && (m_stat == STAT_AOK) && (w_stat == STAT_AOK)
                   && (alu_fun <= ALU_XOR);
    assign arith = (alu_fun == ALU_ADD) || (alu_fun == ALU_SUB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zf <= RST_ZF;
            sf <= RST_SF;
            of <= RST_OF;
        end else if (upd) begin
            zf <= (alu_out == '0);
            sf <= alu_out[WIDTH-1];
            of <= arith ? alu_ovf : 1'b0;
        end
    end

    cc_cond_eval u_cond_eval (
        .cond_fun (cond_fun),
        .zf       (zf),
        .sf       (sf),
        .of       (of),
        .cnd      (cnd)
    );

`ifdef CC_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eval_cnt  <= '0;
            taken_cnt <= '0;
        end else if (eval_valid) begin
            if (eval_cnt != '1) begin
                eval_cnt <= eval_cnt + CNT_ONE;
            end
            if (cnd && (taken_cnt != '1)) begin
                taken_cnt <= taken_cnt + CNT_ONE;
            end
        end
    end
`else
    logic [CNT_W:0] unused_stats;
    assign unused_stats = {eval_valid, {CNT_W{1'b0}}};
`endif

endmodule
